// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter_if
//  Brief    : Requester-side handshake and APB bus bundle for the two-port
//             APB master arbiter. The master modport is the arbiter's view.
//             The slave modport is the environment's view: the requesters
//             plus the APB completer.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // Requester side
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_accept;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    // APB side
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_accept, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_accept, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter
//  Brief    : Two-requester round-robin arbiter driving a single APB master
//             port (IDLE/SETUP/ACCESS), with an optional wait-state timeout
//             that aborts a stalled transfer and reports it as an error.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_master_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Timeout fires when the counter shows TIMEOUT-1 earlier low cycles and
    // the current ACCESS cycle also ends with PREADY low.
    localparam bit         c_timeout_en   = (TIMEOUT > 0);
    localparam logic [7:0] c_timeout_last = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    state_t              state_q,      state_d;
    logic                psel_q,       psel_d;
    logic                penable_q,    penable_d;
    logic                pwrite_q,     pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,      paddr_d;
    logic [DATA_W-1:0]   pwdata_q,     pwdata_d;
    logic [1:0]          req_accept_q, req_accept_d;
    logic [1:0]          rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,  rsp_rdata_d;
    logic                rsp_err_q,    rsp_err_d;
    logic [7:0]          wait_cnt_q,   wait_cnt_d;
    logic                owner_q,      owner_d;
    logic                last_q,       last_d;

    logic                w_any_valid;
    logic                w_grant_idx;
    logic                w_arb_go;

    // Round-robin pick: on a conflict the requester not granted last wins,
    // otherwise whichever one is asking.
    always_comb begin
        w_any_valid = |bus.req_valid;
        if (&bus.req_valid) begin
            w_grant_idx = ~last_q;
        end else begin
            w_grant_idx = bus.req_valid[1];
        end
    end

    // Next-state and next-output computation for the whole transfer engine.
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        req_accept_d = 2'b00;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        wait_cnt_d   = wait_cnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        w_arb_go     = 1'b0;

        case (state_q)
            IDLE: begin
                w_arb_go = w_any_valid;
            end

            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = 8'd0;
            end

            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d            = 1'b0;
                    if (w_any_valid) begin
                        w_arb_go = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (c_timeout_en && (wait_cnt_q == c_timeout_last)) begin
                    // Abort: pending requests wait until IDLE re-arbitrates.
                    state_d              = IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Grant: capture the winner's request and open a SETUP phase.
        if (w_arb_go) begin
            state_d                   = SETUP;
            psel_d                    = 1'b1;
            penable_d                 = 1'b0;
            pwrite_d                  = bus.req_write[w_grant_idx];
            paddr_d                   = w_grant_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                                    : bus.req_addr[ADDR_W-1:0];
            pwdata_d                  = w_grant_idx ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                                    : bus.req_wdata[DATA_W-1:0];
            req_accept_d[w_grant_idx] = 1'b1;
            owner_d                   = w_grant_idx;
            last_d                    = w_grant_idx;
        end
    end

    // State and registered outputs; reset leaves requester 0 first in line.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            req_accept_q <= 2'b00;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            wait_cnt_q   <= 8'd0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            req_accept_q <= req_accept_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            wait_cnt_q   <= wait_cnt_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
        end
    end

    assign bus.PSEL       = psel_q;
    assign bus.PENABLE    = penable_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
    assign bus.req_accept = req_accept_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_arbiter
//  Brief    : Self-checking bench for apb_master_arbiter: directed scenarios
//             plus a randomized run against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_arbiter;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    apb_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    // {PSEL, PENABLE, req_accept[1:0], rsp_valid[1:0]}
    function automatic logic [5:0] bus_stat();
        return {bus.PSEL, bus.PENABLE, bus.req_accept, bus.rsp_valid};
    endfunction

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_valid[i]                 = v;
        bus.req_write[i]                 = w;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESETn = 1'b0;
        clear_inputs();
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if ({bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.rsp_err} !== '0)
            begin errors++; $display("FAIL reset_async got %h exp 0",
                {bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.rsp_err}); end
        set_req(0, 1'b1, 1'b1, 4'h5, 8'h11);
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PADDR} !== '0)
            begin errors++; $display("FAIL reset_hold got %h exp 0", {bus_stat(), bus.PADDR}); end
        clear_inputs();
        PRESETn = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge PCLK);
        set_req(0, 1'b1, 1'b1, 4'h0, 8'h03);
        bus.PREADY = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA} !== {6'b10_01_00, 1'b1, 4'h0, 8'h03})
            begin errors++; $display("FAIL wr_setup got %h exp %h",
                {bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA}, {6'b10_01_00, 1'b1, 4'h0, 8'h03}); end
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA} !== {6'b11_00_00, 1'b1, 4'h0, 8'h03})
            begin errors++; $display("FAIL wr_access got %h exp %h",
                {bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA}, {6'b11_00_00, 1'b1, 4'h0, 8'h03}); end
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.rsp_err, bus.rsp_rdata} !== {6'b00_00_01, 1'b0, 8'h00})
            begin errors++; $display("FAIL wr_rsp got %h exp %h",
                {bus_stat(), bus.rsp_err, bus.rsp_rdata}, {6'b00_00_01, 1'b0, 8'h00}); end
    endtask

    task automatic test_both();
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'h5, 8'hA5);
        set_req(1, 1'b1, 1'b0, 4'h9, 8'h00);
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'h3C;
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PADDR} !== {6'b10_01_00, 4'h5})
            begin errors++; $display("FAIL both_c1 got %h exp %h", {bus_stat(), bus.PADDR}, {6'b10_01_00, 4'h5}); end
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PADDR} !== {6'b11_00_00, 4'h5})
            begin errors++; $display("FAIL both_c2 got %h exp %h", {bus_stat(), bus.PADDR}, {6'b11_00_00, 4'h5}); end
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PADDR, bus.PWRITE, bus.rsp_err, bus.rsp_rdata} !== {6'b10_10_01, 4'h9, 1'b0, 1'b0, 8'h00})
            begin errors++; $display("FAIL both_c3 got %h exp %h",
                {bus_stat(), bus.PADDR, bus.PWRITE, bus.rsp_err, bus.rsp_rdata}, {6'b10_10_01, 4'h9, 1'b0, 1'b0, 8'h00}); end
        set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PADDR} !== {6'b11_00_00, 4'h9})
            begin errors++; $display("FAIL both_c4 got %h exp %h", {bus_stat(), bus.PADDR}, {6'b11_00_00, 4'h9}); end
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.rsp_err, bus.rsp_rdata} !== {6'b00_00_10, 1'b0, 8'h3C})
            begin errors++; $display("FAIL both_c5 got %h exp %h",
                {bus_stat(), bus.rsp_err, bus.rsp_rdata}, {6'b00_00_10, 1'b0, 8'h3C}); end
    endtask

    task automatic test_read_wait();
        int  n    = 0;
        bit  seen = 0;
        @(negedge PCLK);
        set_req(1, 1'b1, 1'b0, 4'h2, 8'h00);
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PADDR} !== {6'b10_10_00, 4'h2})
            begin errors++; $display("FAIL rdw_setup got %h exp %h", {bus_stat(), bus.PADDR}, {6'b10_10_00, 4'h2}); end
        set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge PCLK);
            if (bus.rsp_valid != 2'b00) seen = 1;
            if (bus.PSEL && bus.PENABLE) n++;
            bus.PREADY = (n == 4);
            bus.PRDATA = (n == 4) ? 8'h19 : 8'hE7;
        end
        checks++;
        if (!seen || n != 4)
            begin errors++; $display("FAIL rdw_penable got %0d exp 4 (rsp seen %0d)", n, seen); end
        checks++;
        if ({bus_stat(), bus.rsp_err, bus.rsp_rdata} !== {6'b00_00_10, 1'b0, 8'h19})
            begin errors++; $display("FAIL rdw_rsp got %h exp %h",
                {bus_stat(), bus.rsp_err, bus.rsp_rdata}, {6'b00_00_10, 1'b0, 8'h19}); end
    endtask

    task automatic test_timeout();
        int n    = 0;
        bit seen = 0;
        // Stalled completer: abort after TIMEOUT low ACCESS cycles.
        @(negedge PCLK);
        set_req(0, 1'b1, 1'b0, 4'h7, 8'h00);
        bus.PREADY = 1'b0;
        bus.PRDATA = 8'hAB;
        @(negedge PCLK);
        checks++;
        if (bus_stat() !== 6'b10_01_00)
            begin errors++; $display("FAIL to_setup got %h exp %h", bus_stat(), 6'b10_01_00); end
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(1, 1'b1, 1'b1, 4'hC, 8'h77);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge PCLK);
            if (bus.rsp_valid != 2'b00) seen = 1;
            if (bus.PSEL && bus.PENABLE) n++;
        end
        checks++;
        if (!seen || n != TIMEOUT)
            begin errors++; $display("FAIL to_cycles got %0d exp %0d (rsp seen %0d)", n, TIMEOUT, seen); end
        checks++;
        if ({bus_stat(), bus.rsp_err, bus.rsp_rdata} !== {6'b00_00_01, 1'b1, 8'h00})
            begin errors++; $display("FAIL to_abort got %h exp %h",
                {bus_stat(), bus.rsp_err, bus.rsp_rdata}, {6'b00_00_01, 1'b1, 8'h00}); end
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'hEE;
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.PADDR, bus.PWRITE, bus.PWDATA} !== {6'b10_10_00, 4'hC, 1'b1, 8'h77})
            begin errors++; $display("FAIL to_next got %h exp %h",
                {bus_stat(), bus.PADDR, bus.PWRITE, bus.PWDATA}, {6'b10_10_00, 4'hC, 1'b1, 8'h77}); end
        set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({bus_stat(), bus.rsp_err, bus.rsp_rdata} !== {6'b00_00_10, 1'b0, 8'h00})
            begin errors++; $display("FAIL to_next_rsp got %h exp %h",
                {bus_stat(), bus.rsp_err, bus.rsp_rdata}, {6'b00_00_10, 1'b0, 8'h00}); end

        // PREADY on the last allowed cycle wins over the timeout.
        n = 0;
        seen = 0;
        set_req(0, 1'b1, 1'b0, 4'h3, 8'h00);
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge PCLK);
            if (bus.rsp_valid != 2'b00) seen = 1;
            if (bus.PSEL && bus.PENABLE) n++;
            bus.PREADY = (n == TIMEOUT);
            bus.PRDATA = (n == TIMEOUT) ? 8'h5A : 8'h00;
        end
        checks++;
        if (!seen || n != TIMEOUT)
            begin errors++; $display("FAIL to_edge_cycles got %0d exp %0d (rsp seen %0d)", n, TIMEOUT, seen); end
        checks++;
        if ({bus_stat(), bus.rsp_err, bus.rsp_rdata} !== {6'b00_00_01, 1'b0, 8'h5A})
            begin errors++; $display("FAIL to_edge_rsp got %h exp %h",
                {bus_stat(), bus.rsp_err, bus.rsp_rdata}, {6'b00_00_01, 1'b0, 8'h5A}); end
    endtask

    task automatic test_alternate();
        int exp_w    = 0;
        int got      = 0;
        int last_cyc = 0;
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'h1, 8'h10);
        set_req(1, 1'b1, 1'b1, 4'h2, 8'h20);
        bus.PREADY = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge PCLK);
            if (bus.req_accept != 2'b00) begin
                checks++;
                if (bus.req_accept !== (2'b01 << exp_w))
                    begin errors++; $display("FAIL alt_grant #%0d got %b exp %b", got, bus.req_accept, 2'b01 << exp_w); end
                if (got > 0) begin
                    checks++;
                    if (c - last_cyc != 2)
                        begin errors++; $display("FAIL alt_spacing #%0d got %0d exp 2", got, c - last_cyc); end
                end
                last_cyc = c;
                exp_w    = 1 - exp_w;
                got++;
            end
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL alt_count got %0d exp 8", got); end
        clear_inputs();
        bus.PREADY = 1'b1;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        @(negedge PCLK);
        set_req(0, 1'b1, 1'b1, 4'h1, 8'h42);
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge PCLK);
        checks++;
        if (bus_stat() !== 6'b11_00_00)
            begin errors++; $display("FAIL rm_access got %h exp %h", bus_stat(), 6'b11_00_00); end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if ({bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_err, bus.rsp_rdata} !== '0)
            begin errors++; $display("FAIL rm_async got %h exp 0",
                {bus_stat(), bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_err, bus.rsp_rdata}); end
        bus.PREADY = 1'b1;
        repeat (2) begin
            @(negedge PCLK);
            if (bus.rsp_valid != 2'b00) spurious++;
        end
        PRESETn = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'h4, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'h8, 8'h00);
        @(negedge PCLK);
        if (bus.rsp_valid != 2'b00) spurious++;
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL rm_no_rsp got %0d exp 0", spurious); end
        checks++;
        if ({bus_stat(), bus.PADDR} !== {6'b10_01_00, 4'h4})
            begin errors++; $display("FAIL rm_first_grant got %h exp %h", {bus_stat(), bus.PADDR}, {6'b10_01_00, 4'h4}); end
        clear_inputs();
        bus.PREADY = 1'b1;
        repeat (5) @(negedge PCLK);
    endtask

    // Random traffic checked against a transaction-level model: round-robin
    // grant choice, one transfer at a time, abort iff the completer stalls
    // TIMEOUT or more cycles, read data returned only for good reads.
    task automatic test_random();
        logic [1:0]        pend       = 2'b00;
        logic [1:0]        prev_valid = 2'b00;
        logic              tw[2];
        logic [ADDR_W-1:0] ta[2];
        logic [DATA_W-1:0] td[2];
        int                model_last = 1;
        int                outstanding = 0;
        bit                idle_prev   = 1;
        int                e_owner = 0, e_waits = 0, acc_cnt = 0;
        logic              e_write = 1'b0;
        logic [ADDR_W-1:0] e_addr  = '0;
        logic [DATA_W-1:0] e_wdata = '0, e_rdata = '0;
        bit                exp_err, normal_done, exp_acc, drained = 0;
        int                w, exp_cnt, done = 0;
        logic [DATA_W-1:0] exp_rd;

        do_reset();
        for (int i = 0; i < 2; i++) begin
            tw[i] = 1'b0; ta[i] = '0; td[i] = '0;
        end
        for (int cyc = 0; cyc < 1500 && !drained; cyc++) begin
            @(negedge PCLK);
            exp_err     = 0;
            normal_done = 0;
            if (bus.rsp_valid != 2'b00) begin
                exp_err = (e_waits >= TIMEOUT);
                exp_rd  = (exp_err || e_write) ? '0 : e_rdata;
                exp_cnt = exp_err ? TIMEOUT : e_waits + 1;
                checks++;
                if (outstanding == 0 || bus.rsp_valid !== (2'b01 << e_owner))
                    begin errors++; $display("FAIL rnd_rsp_owner got %b exp %b (outstanding %0d)",
                        bus.rsp_valid, 2'b01 << e_owner, outstanding); end
                checks++;
                if ({bus.rsp_err, bus.rsp_rdata} !== {exp_err, exp_rd})
                    begin errors++; $display("FAIL rnd_rsp_data got %h exp %h", {bus.rsp_err, bus.rsp_rdata}, {exp_err, exp_rd}); end
                checks++;
                if (acc_cnt != exp_cnt)
                    begin errors++; $display("FAIL rnd_access_len got %0d exp %0d", acc_cnt, exp_cnt); end
                normal_done = !exp_err;
                outstanding = 0;
                done++;
            end

            exp_acc = (prev_valid != 2'b00) && (idle_prev || normal_done);
            checks++;
            if ((bus.req_accept != 2'b00) !== exp_acc)
                begin errors++; $display("FAIL rnd_accept_when got %b exp_any %0d", bus.req_accept, exp_acc); end

            if (bus.req_accept != 2'b00) begin
                w = (prev_valid == 2'b11) ? 1 - model_last : (prev_valid[1] ? 1 : 0);
                checks++;
                if (bus.req_accept !== (2'b01 << w))
                    begin errors++; $display("FAIL rnd_grant got %b exp %b", bus.req_accept, 2'b01 << w); end
                checks++;
                if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {2'b10, tw[w], ta[w], td[w]})
                    begin errors++; $display("FAIL rnd_setup got %h exp %h",
                        {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, {2'b10, tw[w], ta[w], td[w]}); end
                model_last  = w;
                e_owner     = w;
                e_write     = tw[w];
                e_addr      = ta[w];
                e_wdata     = td[w];
                e_waits     = $urandom_range(0, 5);
                e_rdata     = DATA_W'($urandom_range(1, 255));
                acc_cnt     = 0;
                outstanding = 1;
                pend[w]     = 1'b0;
            end

            // Completer model
            if (bus.PSEL && bus.PENABLE) begin
                acc_cnt++;
                checks++;
                if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== {e_write, e_addr, e_wdata})
                    begin errors++; $display("FAIL rnd_stable got %h exp %h",
                        {bus.PWRITE, bus.PADDR, bus.PWDATA}, {e_write, e_addr, e_wdata}); end
                bus.PREADY = (acc_cnt == e_waits + 1);
                bus.PRDATA = (acc_cnt == e_waits + 1) ? e_rdata : DATA_W'($urandom);
            end else begin
                bus.PREADY = 1'($urandom);
                bus.PRDATA = DATA_W'($urandom);
            end

            // Requester models
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    tw[i] = 1'($urandom);
                    ta[i] = ADDR_W'($urandom);
                    td[i] = DATA_W'($urandom);
                    if (cyc < 1000 && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
                end
                set_req(i, pend[i], tw[i], ta[i], td[i]);
            end
            prev_valid = pend;
            idle_prev  = (outstanding == 0);
            drained    = (cyc >= 1000) && (pend == 2'b00) && (outstanding == 0);
        end
        checks++;
        if (!drained || done < 50)
            begin errors++; $display("FAIL rnd_drain got drained=%0d transfers=%0d exp drained with >=50", drained, done); end
        clear_inputs();
        repeat (3) @(negedge PCLK);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_both();
        test_read_wait();
        test_timeout();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum consecutive ACCESS wait cycles before abort; 0 disables timeout; value range 0..255.
REQ-004 The block SHALL have one clock and reset SHALL be asynchronous and active-low; clock is PCLK, reset is PRESETn.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  async active-low reset
- req_valid  in  2  request pending, bit i = requester i
- req_write  in  2  1 = write, 0 = read, per requester
- req_addr  in  2*ADDR_W  address, requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  write data, requester i at bits [i*DATA_W +: DATA_W]
- req_accept  out  2  one-cycle pulse, request i captured
- rsp_valid  out  2  one-cycle pulse, transfer of requester i finished
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- rsp_err  out  1  timeout abort flag, valid with rsp_valid
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready, wait state when low

Function
REQ-006 The block SHALL implement FSM states IDLE, SETUP, ACCESS; all APB and requester-side outputs SHALL be registered.
REQ-007 IDLE: if any req_valid is high at an edge, the block SHALL arbitrate, latch winner addr/write/wdata into PADDR/PWRITE/PWDATA, and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-008 SETUP: PSEL=1, PENABLE=0 for exactly one cycle; req_accept[winner]=1 in this same cycle only; next state is always ACCESS.
REQ-009 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL be held stable from SETUP through the end of ACCESS.
REQ-010 ACCESS with PREADY=1 at an edge: transfer completes; rsp_valid[owner]=1 next cycle; rsp_rdata = PRDATA sampled at that edge for reads, 0 for writes; rsp_err=0.
REQ-011 On completion, if any req_valid is high, the block SHALL arbitrate and go directly to SETUP (PSEL stays 1, PENABLE drops to 0); otherwise it SHALL go to IDLE with PSEL=0, PENABLE=0.
REQ-012 Arbitration SHALL be round-robin over 2 requesters: on a conflict the requester not granted last wins; a lone requester always wins; the last-grant pointer updates only on grant.
REQ-013 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-014 If TIMEOUT>0 and the TIMEOUT-th consecutive PREADY=0 ACCESS cycle ends, the block SHALL abort: PSEL=0, PENABLE=0 next cycle, rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, then go to IDLE regardless of pending requests.
REQ-015 PREADY=1 in the same cycle the timeout would fire SHALL complete normally (REQ-010) with no error.
REQ-016 Requesters hold req_valid/addr/wdata stable until req_accept; the block SHALL ignore req_valid outside IDLE and outside completion/arbitration edges.
REQ-017 Minimum latency SHALL be: valid seen at edge k, SETUP in cycle k+1, ACCESS in cycle k+2, rsp_valid in cycle k+3 with zero wait states; back-to-back throughput SHALL be one transfer per 2 cycles.
REQ-018 rsp_valid SHALL never be high for both bits at once; req_accept likewise.
REQ-019 In IDLE, PADDR/PWRITE/PWDATA SHALL hold their last values; rsp_rdata/rsp_err SHALL hold until the next rsp_valid.

Reset
REQ-020 PRESETn low SHALL force, without waiting for a clock edge: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_accept=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, last-grant pointer=1 so requester 0 wins first.
REQ-021 A transfer in flight when reset asserts SHALL be dropped with no rsp_valid; after release the block SHALL resume from IDLE at the first edge.

Verification
REQ-022 Write from req0 (addr 0, data 0x03, PREADY=1) -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid[0] in 3rd cycle, rsp_err=0, PWDATA=0x03 stable both phases.
REQ-023 Both request in the same cycle after reset, PREADY=1 -> req0 is served first, then req1 with PSEL high continuously, 4 cycles total, accept pulses in cycles 1 and 3.
REQ-024 Read from req1 (addr 2), PREADY low for 3 cycles then high with PRDATA=0x19 -> PENABLE high 4 cycles, rsp_valid[1]=1, rsp_rdata=0x19.
REQ-025 TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0, IDLE even with req_valid pending; same case with PREADY=1 on the 4th cycle -> normal completion.
REQ-026 Both requesters continuously valid -> grants alternate 0,1,0,1 over 8 transfers.
REQ-027 PRESETn asserted mid-ACCESS -> PSEL/PENABLE go to 0 before the next edge, no rsp_valid, and the next grant after release goes to req0.
